npm_toggle_cal_seq: RTL and testbench

NPM_TOGGLE_CAL_SEQ -- requirements
Module: npm_toggle_cal_seq

---
 rtl/npm_toggle_cal_seq_if.sv | 25 ++
 rtl/npm_toggle_cal_seq.sv | 71 +++++++
 tb/tb_npm_toggle_cal_seq.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/npm_toggle_cal_seq_if.sv
// npm_toggle_cal_seq_if: PM-side CAL trigger/byte stream and NAND pin bundle for the CAL sequencer
interface npm_toggle_cal_seq_if #(parameter int NumberOfWays = 4);
  logic [7:0]              iPCommand;
  logic [NumberOfWays-1:0] iTargetWay;
  logic [15:0]             iNumOfData;
  logic                    iCASelect;
  logic [7:0]              iCAData;
  logic                    oReady;
  logic                    oLastStep;
  logic                    oOverflow;
  logic [NumberOfWays-1:0] oCE_n;
  logic                    oCLE;
  logic                    oALE;
  logic                    oWE_n;
  logic [7:0]              oDQ;
  logic                    oDQOutEn;
  modport master (
    output iPCommand, iTargetWay, iNumOfData, iCASelect, iCAData,
    input  oReady, oLastStep, oOverflow, oCE_n, oCLE, oALE, oWE_n, oDQ, oDQOutEn
  );
  modport slave (
    input  iPCommand, iTargetWay, iNumOfData, iCASelect, iCAData,
    output oReady, oLastStep, oOverflow, oCE_n, oCLE, oALE, oWE_n, oDQ, oDQOutEn
  );
endinterface

// File: rtl/npm_toggle_cal_seq.sv
// npm_toggle_cal_seq: buffers up to 8 command/address bytes after a CAL trigger, then strobes them out on WE_n
module npm_toggle_cal_seq #(parameter int NumberOfWays = 4) (
  input logic                iSystemClock,
  input logic                iReset,
  npm_toggle_cal_seq_if.slave bus
);
  typedef enum logic [2:0] {S_IDLE, S_CAPTURE, S_ISSUE_LOW, S_ISSUE_HIGH, S_TAIL, S_DONE} state_t;
  state_t                  r_state, w_next;
  logic [NumberOfWays-1:0] r_way;
  logic [15:0]             r_cap_left;
  logic [3:0]              r_wr_ptr;
  logic [2:0]              r_rd_ptr;
  logic [2:0]              r_last;
  logic                    r_overflow;
  logic [8:0]              r_buf [8];
  logic                    w_trigger, w_issue, w_unused;
  logic [8:0]              w_byte;
  assign w_trigger = (r_state == S_IDLE) && bus.iPCommand[3];
  assign w_issue   = (r_state == S_ISSUE_LOW) || (r_state == S_ISSUE_HIGH);
  assign w_byte    = r_buf[r_rd_ptr];
  assign w_unused  = ^{bus.iPCommand[7:4], bus.iPCommand[2:0]};
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:       w_next = w_trigger ? S_CAPTURE : S_IDLE;
      S_CAPTURE:    w_next = (r_cap_left == 16'd0) ? S_ISSUE_LOW : S_CAPTURE;
      S_ISSUE_LOW:  w_next = S_ISSUE_HIGH;
      S_ISSUE_HIGH: w_next = (r_rd_ptr == r_last) ? S_TAIL : S_ISSUE_LOW;
      S_TAIL:       w_next = S_DONE;
      default:      w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge iSystemClock) begin
    if (iReset) begin
      r_state    <= S_IDLE;
      r_way      <= '0;
      r_cap_left <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_last     <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_trigger) begin
        r_way      <= bus.iTargetWay;
        r_cap_left <= bus.iNumOfData;
        r_wr_ptr   <= '0;
        r_rd_ptr   <= '0;
        r_last     <= (bus.iNumOfData > 16'd7) ? 3'd7 : bus.iNumOfData[2:0];
        r_overflow <= bus.iNumOfData > 16'd7;
      end
      // capture keeps running for the full requested count; the pointer just parks at 8
      if (r_state == S_CAPTURE) begin
        r_cap_left <= r_cap_left - 16'd1;
        if (!r_wr_ptr[3]) r_wr_ptr <= r_wr_ptr + 4'd1;
      end
      if (r_state == S_ISSUE_HIGH && r_rd_ptr != r_last) r_rd_ptr <= r_rd_ptr + 3'd1;
    end
  end
  always_ff @(posedge iSystemClock)
    if (r_state == S_CAPTURE && !r_wr_ptr[3]) r_buf[r_wr_ptr[2:0]] <= {bus.iCASelect, bus.iCAData};
  assign bus.oReady    = r_state == S_IDLE;
  assign bus.oLastStep = r_state == S_DONE;
  assign bus.oOverflow = r_overflow;
  assign bus.oCE_n     = (w_issue || r_state == S_TAIL) ? ~r_way : '1;
  assign bus.oCLE      = w_issue && !w_byte[8];
  assign bus.oALE      = w_issue && w_byte[8];
  assign bus.oWE_n     = r_state != S_ISSUE_LOW;
  assign bus.oDQ       = w_issue ? w_byte[7:0] : 8'h00;
  assign bus.oDQOutEn  = w_issue;
endmodule

// File: tb/tb_npm_toggle_cal_seq.sv
// tb_npm_toggle_cal_seq: directed scenarios for the CAL sequencer with cycle-exact pin expectations
module tb_npm_toggle_cal_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  npm_toggle_cal_seq_if #(.NumberOfWays(4)) bus();
  npm_toggle_cal_seq #(.NumberOfWays(4)) dut (.iSystemClock(clk), .iReset(rst), .bus(bus));
  int          n_checks = 0;
  int          n_fail = 0;
  logic [8:0]  bytes [16];
  logic [63:0] we_mask;
  int          last_cyc, last_cnt;
  logic [17:0] obs;
  localparam logic [17:0] IdleVec = {1'b1, 1'b0, 4'hF, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0};
  assign obs = {bus.oReady, bus.oLastStep, bus.oCE_n, bus.oCLE, bus.oALE, bus.oWE_n, bus.oDQ, bus.oDQOutEn};

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // trigger in the current (idle) cycle, then check every pin each cycle up to the return to Idle
  task automatic test_sequence(input string name, input logic [3:0] way, input logic [15:0] nod, input logic [7:0] hold);
    int c, n, fin, off;
    logic iss;
    logic [8:0] b;
    logic [17:0] exp;
    c = int'(nod) + 1;
    n = (nod > 16'd7) ? 8 : c;
    fin = c + 2 * n + 3;
    we_mask = '0; last_cyc = -1; last_cnt = 0;
    bus.iPCommand = 8'h08; bus.iTargetWay = way; bus.iNumOfData = nod;
    bus.iCASelect = 1'b0; bus.iCAData = 8'h00;
    n_checks++;
    if (bus.oReady !== 1'b1) begin
      n_fail++;
      $display("FAIL %s trigger_ready: got %b want 1", name, bus.oReady);
    end
    for (int k = 1; k <= fin; k++) begin
      step();
      bus.iPCommand  = (k == fin) ? 8'h01 : hold;
      bus.iTargetWay = 4'hA;
      bus.iNumOfData = 16'hFFFF;
      bus.iCASelect  = (k <= c) ? bytes[k-1][8] : 1'b1;
      bus.iCAData    = (k <= c) ? bytes[k-1][7:0] : 8'hEE;
      iss = (k >= c + 1) && (k <= c + 2 * n);
      off = k - c - 1;
      b = 9'h000;
      if (iss) b = bytes[off / 2];
      exp = {k == fin, k == c + 2 * n + 2, (k >= c + 1 && k <= c + 2 * n + 1) ? ~way : 4'hF,
             iss && !b[8], iss && b[8], !(iss && off % 2 == 0), b[7:0], iss};
      if (!bus.oWE_n) we_mask[k] = 1'b1;
      if (bus.oLastStep) begin last_cnt++; last_cyc = k; end
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL %s cycle %0d pins {rdy,last,ce_n,cle,ale,we_n,dq,oe}: got %h want %h", name, k, obs, exp);
      end
    end
  endtask

  task automatic test_reset;
    bus.iPCommand = 8'h08; bus.iTargetWay = 4'hF; bus.iNumOfData = 16'd3;
    bus.iCASelect = 1'b0; bus.iCAData = 8'h00;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      n_checks++;
      if (obs !== IdleVec || bus.oOverflow !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_hold cycle %0d: got %h ovf %b want %h ovf 0", k, obs, bus.oOverflow, IdleVec);
      end
    end
    bus.iPCommand = 8'h00;
    rst = 1'b0;
    step();
    n_checks++;
    if (obs !== IdleVec) begin
      n_fail++;
      $display("FAIL reset_release: got %h want %h", obs, IdleVec);
    end
  endtask

  task automatic test_erase;
    bytes[0] = 9'h0A2; bytes[1] = 9'h060; bytes[2] = 9'h101;
    bytes[3] = 9'h102; bytes[4] = 9'h103; bytes[5] = 9'h0D0;
    test_sequence("erase", 4'b0010, 16'd5, 8'h00);
    n_checks++;
    if (we_mask !== 64'h2AA80) begin n_fail++; $display("FAIL erase_we_cycles: got %h want 2aa80", we_mask); end
    n_checks++;
    if (last_cyc != 20 || last_cnt != 1) begin n_fail++; $display("FAIL erase_laststep: got T%0d x%0d want T20 x1", last_cyc, last_cnt); end
    n_checks++;
    if (bus.oOverflow !== 1'b0) begin n_fail++; $display("FAIL erase_overflow: got %b want 0", bus.oOverflow); end
  endtask

  task automatic test_single;
    bytes[0] = 9'h070;
    test_sequence("single", 4'b1000, 16'd0, 8'h00);
    n_checks++;
    if (we_mask !== 64'h4) begin n_fail++; $display("FAIL single_we_cycles: got %h want 4", we_mask); end
    n_checks++;
    if (last_cyc != 5 || bus.oReady !== 1'b1) begin n_fail++; $display("FAIL single_done: got T%0d ready %b want T5 ready 1", last_cyc, bus.oReady); end
  endtask

  task automatic test_overflow;
    for (int i = 0; i < 8; i++) bytes[i] = {i[0], 8'h30 + 8'(i)};
    bytes[8] = 9'h1F8; bytes[9] = 9'h0F9;
    test_sequence("overflow", 4'b0100, 16'd9, 8'h00);
    n_checks++;
    if (bus.oOverflow !== 1'b1) begin n_fail++; $display("FAIL overflow_set: got %b want 1", bus.oOverflow); end
    n_checks++;
    if (we_mask !== 64'h2AAA800 || last_cnt != 1) begin
      n_fail++;
      $display("FAIL overflow_pulses: got we %h last x%0d want we 2aaa800 last x1", we_mask, last_cnt);
    end
    bytes[0] = 9'h011; bytes[1] = 9'h122; bytes[2] = 9'h033;
    test_sequence("overflow_clear", 4'b0001, 16'd2, 8'h00);
    n_checks++;
    if (bus.oOverflow !== 1'b0) begin n_fail++; $display("FAIL overflow_clear: got %b want 0", bus.oOverflow); end
  endtask

  task automatic test_hold;
    bytes[0] = 9'h0E0; bytes[1] = 9'h1E1; bytes[2] = 9'h1E2; bytes[3] = 9'h0E3;
    test_sequence("hold", 4'b1001, 16'd3, 8'h08);
    for (int k = 0; k < 4; k++) begin
      step();
      if (bus.oLastStep) last_cnt++;
      n_checks++;
      if (bus.oReady !== 1'b1) begin n_fail++; $display("FAIL hold_bit0_idle cycle %0d: ready got %b want 1", k, bus.oReady); end
    end
    n_checks++;
    if (last_cnt != 1) begin n_fail++; $display("FAIL hold_single_run: laststep got x%0d want x1", last_cnt); end
  endtask

  task automatic test_reset_mid;
    bus.iPCommand = 8'h08; bus.iTargetWay = 4'b0001; bus.iNumOfData = 16'd9;
    bus.iCASelect = 1'b0; bus.iCAData = 8'h5A;
    for (int k = 1; k <= 13; k++) begin
      step();
      bus.iPCommand = 8'h00;
    end
    n_checks++;
    if (bus.oWE_n !== 1'b0 || bus.oCE_n !== 4'hE || bus.oOverflow !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_second_low: got we_n %b ce_n %h ovf %b want 0 e 1", bus.oWE_n, bus.oCE_n, bus.oOverflow);
    end
    rst = 1'b1;
    step();
    n_checks++;
    if (obs !== IdleVec || bus.oOverflow !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: got %h ovf %b want %h ovf 0", obs, bus.oOverflow, IdleVec);
    end
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      n_checks++;
      if (obs !== IdleVec) begin n_fail++; $display("FAIL mid_after cycle %0d: got %h want %h", k, obs, IdleVec); end
    end
  endtask

  initial begin
    test_reset();
    test_erase();
    test_single();
    test_overflow();
    test_hold();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
